// File: rtl/iagc_phase_sequencer_if.sv
// iagc_phase_sequencer_if: signal bundle between the IAGC top FSM, the phase sequencer and the phase detector
// i_enable      run level from the IAGC top FSM
// i_in_phase    in-phase verdict from the phase detector
// o_iagc_status status word to the detector and top level
// o_gate        one-cycle sample strobe to the detector
// o_invert      error-path polarity select (1 = inverted)
// o_locked      phase lock achieved
// o_fault       lock failed after the allowed attempts
interface iagc_phase_sequencer_if #(
    parameter int IAGC_STATUS_SIZE = 4
);
    logic                        i_enable;
    logic                        i_in_phase;
    logic [IAGC_STATUS_SIZE-1:0] o_iagc_status;
    logic                        o_gate;
    logic                        o_invert;
    logic                        o_locked;
    logic                        o_fault;
    modport master (
        output i_enable, i_in_phase,
        input  o_iagc_status, o_gate, o_invert, o_locked, o_fault
    );
    modport slave (
        input  i_enable, i_in_phase,
        output o_iagc_status, o_gate, o_invert, o_locked, o_fault
    );
endinterface

// File: rtl/iagc_phase_sequencer.sv
// iagc_phase_sequencer: sequences the IAGC phase detector through reset, timed measurement windows and verdict evaluation
// i_clock  single rising-edge clock
// i_reset  synchronous active-high reset
// bus      slave side of iagc_phase_sequencer_if (enable/verdict in; status, gate, invert, locked, fault out)
module iagc_phase_sequencer #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int GATE_DIV         = 10,
    parameter int MEASURE_GATES    = 520,
    parameter int RESET_CYCLES     = 4,
    parameter int MAX_ATTEMPTS     = 2
) (
    input logic                   i_clock,
    input logic                   i_reset,
    iagc_phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_MEASURE, S_EVAL, S_LOCKED, S_FAULT} state_t;

    localparam logic [IAGC_STATUS_SIZE-1:0] ST_IDLE  = '0;
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_MEAS  = IAGC_STATUS_SIZE'(2);
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_LOCK  = IAGC_STATUS_SIZE'(4);
    localparam logic [IAGC_STATUS_SIZE-1:0] ST_FAULT = '1;
    localparam logic [7:0]  DIV_LAST = 8'(GATE_DIV - 1);
    localparam logic [15:0] GATES    = 16'(MEASURE_GATES);
    localparam logic [7:0]  RST_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [3:0]  ATT_LAST = 4'(MAX_ATTEMPTS - 1);

    state_t                      state_q;
    logic [7:0]                  div_q;
    logic [7:0]                  rcnt_q;
    logic [15:0]                 gcnt_q;
    logic [3:0]                  att_q;
    logic [IAGC_STATUS_SIZE-1:0] status_q;
    logic                        gate_q;
    logic                        invert_q;
    logic                        locked_q;
    logic                        fault_q;
    logic                        div_end;
    logic                        window_end;

    assign div_end    = div_q == DIV_LAST;
    // the divider slot that would carry pulse MEASURE_GATES+1 ends the window instead
    assign window_end = div_end && gcnt_q == GATES;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            rcnt_q   <= '0;
            gcnt_q   <= '0;
            att_q    <= '0;
            status_q <= ST_IDLE;
            gate_q   <= 1'b0;
            invert_q <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (!bus.i_enable) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            rcnt_q   <= '0;
            gcnt_q   <= '0;
            att_q    <= '0;
            status_q <= ST_IDLE;
            gate_q   <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            gate_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_RESET;
                    rcnt_q   <= '0;
                    div_q    <= '0;
                    gcnt_q   <= '0;
                    status_q <= ST_IDLE;
                end
                S_RESET: begin
                    rcnt_q <= rcnt_q + 8'd1;
                    if (rcnt_q == RST_LAST) begin
                        state_q  <= S_MEASURE;
                        status_q <= ST_MEAS;
                    end
                end
                S_MEASURE, S_LOCKED: begin
                    div_q <= div_end ? 8'd0 : div_q + 8'd1;
                    if (window_end) begin
                        state_q <= S_EVAL;
                    end else if (div_end) begin
                        gate_q <= 1'b1;
                        gcnt_q <= gcnt_q + 16'd1;
                    end
                end
                S_EVAL: begin
                    // every exit re-enters a counted state, so clear its counters here
                    div_q  <= '0;
                    gcnt_q <= '0;
                    rcnt_q <= '0;
                    if (bus.i_in_phase) begin
                        att_q    <= '0;
                        locked_q <= 1'b1;
                        state_q  <= S_LOCKED;
                        status_q <= ST_LOCK;
                    end else if (locked_q) begin
                        // losing an established lock retries from scratch without flipping polarity
                        att_q    <= '0;
                        locked_q <= 1'b0;
                        state_q  <= S_RESET;
                        status_q <= ST_IDLE;
                    end else if (att_q < ATT_LAST) begin
                        att_q    <= att_q + 4'd1;
                        invert_q <= ~invert_q;
                        state_q  <= S_RESET;
                        status_q <= ST_IDLE;
                    end else begin
                        fault_q  <= 1'b1;
                        state_q  <= S_FAULT;
                        status_q <= ST_FAULT;
                    end
                end
                S_FAULT: begin
                    status_q <= ST_FAULT;
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_iagc_status = status_q;
    assign bus.o_gate        = gate_q;
    assign bus.o_invert      = invert_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_fault       = fault_q;
endmodule

// File: tb/tb_iagc_phase_sequencer.sv
// tb_iagc_phase_sequencer: directed bench with a window-timeline model of the phase sequencer
module tb_iagc_phase_sequencer;
    localparam int GD = 2;
    localparam int MG = 8;
    localparam int RC = 4;
    localparam int MA = 2;
    localparam int W  = (MG + 1) * GD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   gates = 0;
    int   g0;

    // model: mode 0 idle, 1 reset, 2 window (t = cycles since window start; t==W is the verdict cycle), 3 fault
    int   m_mode = 0;
    int   m_t = 0;
    int   m_fails = 0;
    logic m_inv = 1'b0;
    logic m_lock = 1'b0;
    logic m_fault = 1'b0;

    iagc_phase_sequencer_if #(.IAGC_STATUS_SIZE(4)) bus ();

    iagc_phase_sequencer #(
        .IAGC_STATUS_SIZE(4),
        .GATE_DIV(GD),
        .MEASURE_GATES(MG),
        .RESET_CYCLES(RC),
        .MAX_ATTEMPTS(MA)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_t <= 0; m_inv <= 1'b0; m_lock <= 1'b0; m_fault <= 1'b0; m_fails <= 0;
        end else if (!bus.i_enable) begin
            m_mode <= 0; m_t <= 0; m_lock <= 1'b0; m_fault <= 1'b0; m_fails <= 0;
        end else if (m_mode == 0) begin
            m_mode <= 1; m_t <= 0;
        end else if (m_mode == 1) begin
            if (m_t == RC - 1) begin m_mode <= 2; m_t <= 0; end
            else m_t <= m_t + 1;
        end else if (m_mode == 2) begin
            if (m_t != W) m_t <= m_t + 1;
            else if (bus.i_in_phase) begin m_lock <= 1'b1; m_fails <= 0; m_t <= 0; end
            else if (m_lock) begin m_lock <= 1'b0; m_fails <= 0; m_mode <= 1; m_t <= 0; end
            else if (m_fails + 1 < MA) begin m_inv <= ~m_inv; m_fails <= m_fails + 1; m_mode <= 1; m_t <= 0; end
            else begin m_fault <= 1'b1; m_mode <= 3; end
        end
    end

    task automatic check_cycle();
        logic [3:0] es;
        logic       eg;
        es = (m_mode == 2) ? (m_lock ? 4'h4 : 4'h2) : (m_mode == 3) ? 4'hF : 4'h0;
        eg = (m_mode == 2) && (m_t > 0) && (m_t % GD == 0) && (m_t / GD <= MG);
        total++;
        if ({bus.o_iagc_status, bus.o_gate, bus.o_invert, bus.o_locked, bus.o_fault} !== {es, eg, m_inv, m_lock, m_fault}) begin
            bad++;
            $display("FAIL model @%0t status/gate/inv/lock/fault got %h %b%b%b%b want %h %b%b%b%b", $time,
                     bus.o_iagc_status, bus.o_gate, bus.o_invert, bus.o_locked, bus.o_fault,
                     es, eg, m_inv, m_lock, m_fault);
        end
        if (bus.o_gate === 1'b1) gates++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic pin(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_in_phase = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_enable = 1'b0;
        bus.i_in_phase = 1'b0;
        rst = 1'b1;
        step(3);
        pin("reset status", int'(bus.o_iagc_status), 0);
        pin("reset invert", int'(bus.o_invert), 0);
        rst = 1'b0;
        step(10);
        pin("idle status", int'(bus.o_iagc_status), 0);
        pin("idle gate/lock/fault", int'({bus.o_gate, bus.o_locked, bus.o_fault}), 0);

        bus.i_enable = 1'b1;
        bus.i_in_phase = 1'b1;
        step(4);
        pin("reset hold status", int'(bus.o_iagc_status), 0);
        step(1);
        pin("measure entry status", int'(bus.o_iagc_status), 2);
        g0 = gates;
        step(18);
        pin("window gate count", gates - g0, 8);
        pin("eval not yet locked", int'(bus.o_locked), 0);
        step(1);
        pin("first lock", int'(bus.o_locked), 1);
        pin("lock status", int'(bus.o_iagc_status), 4);
        pin("lock invert", int'(bus.o_invert), 0);
        bus.i_in_phase = 1'b0;
        step(18);
        pin("locked through eval", int'(bus.o_locked), 1);
        step(1);
        pin("lock lost", int'(bus.o_locked), 0);
        pin("lock lost status", int'(bus.o_iagc_status), 0);
        pin("lock lost invert", int'(bus.o_invert), 0);
        step(3);
        pin("relock reset hold", int'(bus.o_iagc_status), 0);
        step(1);
        pin("relock measure", int'(bus.o_iagc_status), 2);

        do_reset();
        bus.i_enable = 1'b1;
        bus.i_in_phase = 1'b0;
        step(24);
        pin("flip invert", int'(bus.o_invert), 1);
        pin("flip status", int'(bus.o_iagc_status), 0);
        bus.i_in_phase = 1'b1;
        step(22);
        pin("flip pre-lock", int'(bus.o_locked), 0);
        step(1);
        pin("flip lock", int'(bus.o_locked), 1);
        pin("flip no fault", int'(bus.o_fault), 0);

        do_reset();
        bus.i_enable = 1'b1;
        bus.i_in_phase = 1'b0;
        step(47);
        pin("fault flag", int'(bus.o_fault), 1);
        pin("fault status", int'(bus.o_iagc_status), 15);
        pin("fault one toggle", int'(bus.o_invert), 1);
        g0 = gates;
        step(20);
        pin("fault no gates", gates - g0, 0);
        bus.i_enable = 1'b0;
        step(1);
        pin("fault cleared status", int'(bus.o_iagc_status), 0);
        pin("fault cleared", int'(bus.o_fault), 0);

        do_reset();
        bus.i_enable = 1'b1;
        bus.i_in_phase = 1'b1;
        g0 = gates;
        step(13);
        pin("gate 4 strobe", int'(bus.o_gate), 1);
        pin("gate 4 count", gates - g0, 4);
        rst = 1'b1;
        step(1);
        pin("mid reset status", int'(bus.o_iagc_status), 0);
        pin("mid reset gate", int'(bus.o_gate), 0);
        bus.i_enable = 1'b0;
        step(1);
        rst = 1'b0;

        bus.i_enable = 1'b1;
        bus.i_in_phase = 1'b0;
        step(23);
        pin("race eval status", int'(bus.o_iagc_status), 2);
        bus.i_enable = 1'b0;
        step(1);
        pin("race invert", int'(bus.o_invert), 0);
        pin("race status", int'(bus.o_iagc_status), 0);
        pin("race fault", int'(bus.o_fault), 0);
        step(5);
        pin("race invert hold", int'(bus.o_invert), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
